// File: rtl/traffic_phase_sequencer_pkg.sv
// traffic_phase_sequencer_pkg
//   Shared light codes, phase state encodings, time limits and the timing
//   validity check used when the sequencer samples the committed times.
//   No ports (package).
package traffic_phase_sequencer_pkg;

  typedef enum logic [1:0] {
    LIGHT_OFF    = 2'd0,
    LIGHT_RED    = 2'd1,
    LIGHT_YELLOW = 2'd2,
    LIGHT_GREEN  = 2'd3
  } light_e;

  typedef enum logic [2:0] {
    ST_G1R2   = 3'd0,
    ST_Y1R2   = 3'd1,
    ST_R1G2   = 3'd2,
    ST_R1Y2   = 3'd3,
    ST_CONFIG = 3'd4
  } state_e;

  localparam int unsigned MAX_TIME = 99;
  localparam int unsigned MIN_TIME = 0;

  typedef struct packed {
    logic [6:0] green;
    logic [6:0] yellow;
    logic [6:0] red;
  } times_t;

  // Accept the committed times only when all are in range and red covers
  // exactly green+yellow; otherwise fall back to the supplied defaults.
  function automatic times_t select_times(input logic [6:0] g,
                                          input logic [6:0] y,
                                          input logic [6:0] r,
                                          input times_t     def);
    logic ok;
    ok = (g > 7'(MIN_TIME)) && (y > 7'(MIN_TIME)) && (r > 7'(MIN_TIME)) &&
         (g <= 7'(MAX_TIME)) && (y <= 7'(MAX_TIME)) && (r <= 7'(MAX_TIME)) &&
         (({1'b0, g} + {1'b0, y}) == {1'b0, r});
    if (ok) return '{green: g, yellow: y, red: r};
    return def;
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// traffic_phase_sequencer_if
//   Bundles the button/config-block inputs and the lane driver outputs.
//   master: button front end / config block / lane drivers side
//   slave : traffic_phase_sequencer side
//   Signals: buttonMode, greenTime, yellowTime, redTime (to sequencer);
//            configEnable, lightLane1/2, timeLane1/2 (from sequencer).
interface traffic_phase_sequencer_if;
  import traffic_phase_sequencer_pkg::*;

  logic       buttonMode;
  logic [6:0] greenTime;
  logic [6:0] yellowTime;
  logic [6:0] redTime;
  logic       configEnable;
  light_e     lightLane1;
  light_e     lightLane2;
  logic [6:0] timeLane1;
  logic [6:0] timeLane2;

  modport master (
    output buttonMode, greenTime, yellowTime, redTime,
    input  configEnable, lightLane1, lightLane2, timeLane1, timeLane2
  );

  modport slave (
    input  buttonMode, greenTime, yellowTime, redTime,
    output configEnable, lightLane1, lightLane2, timeLane1, timeLane2
  );

endinterface

// File: rtl/traffic_phase_sequencer_tick_divider.sv
// traffic_phase_sequencer_tick_divider
//   Free-running 0..TICK_DIV-1 counter producing a one-cycle tick in the
//   cycle where the count is TICK_DIV-1. clear_i restarts the count at 0.
//   Ports: clk, reset (async, active-high), clear_i, tick_o.
module traffic_phase_sequencer_tick_divider #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);
  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer
//   Four-phase two-lane light sequencer with per-lane 1 s countdowns and a
//   NORMAL/CONFIG mode toggle on the rising edge of buttonMode. Committed
//   times are sampled at the start of every full light cycle and on CONFIG
//   exit. All outputs are registered.
//   Ports: clk, reset (async, active-high), bus (traffic_phase_sequencer_if.slave).
//   Build option: CONFIG_BLINK_EN - blink both lights YELLOW/OFF in CONFIG.
module traffic_phase_sequencer
  import traffic_phase_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned DEF_GREEN  = 27,
  parameter int unsigned DEF_YELLOW = 3,
  parameter int unsigned DEF_RED    = 30
) (
  input logic                      clk,
  input logic                      reset,
  traffic_phase_sequencer_if.slave bus
);

  localparam times_t DEF_TIMES = '{green:  7'(DEF_GREEN),
                                   yellow: 7'(DEF_YELLOW),
                                   red:    7'(DEF_RED)};
`ifdef CONFIG_BLINK_EN
  localparam light_e CFG_LIGHT = LIGHT_YELLOW;
`else
  localparam light_e CFG_LIGHT = LIGHT_OFF;
`endif

  state_e     state_q, state_d;
  times_t     shadow_q, shadow_d;
  logic       btn_prev_q;
  logic       cfg_q, cfg_d;
  light_e     l1_q, l1_d, l2_q, l2_d;
  logic [6:0] t1_q, t1_d, t2_q, t2_d;
  logic       tick, mode_edge, div_clear;
  times_t     sampled;

  // Counters saturate at 1: normal mode never shows 0.
  function automatic logic [6:0] dec1(input logic [6:0] t);
    return (t > 7'd1) ? t - 7'd1 : t;
  endfunction

  assign mode_edge = bus.buttonMode & ~btn_prev_q;
  assign sampled   = select_times(bus.greenTime, bus.yellowTime, bus.redTime, DEF_TIMES);
  assign div_clear = (state_d != state_q);

  traffic_phase_sequencer_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clear_i (div_clear),
    .tick_o  (tick)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    l1_d     = l1_q;
    l2_d     = l2_q;
    t1_d     = t1_q;
    t2_d     = t2_q;
    case (state_q)
      ST_CONFIG: begin
        if (mode_edge) begin
          state_d  = ST_G1R2;
          shadow_d = sampled;
          cfg_d    = 1'b0;
          l1_d     = LIGHT_GREEN;
          l2_d     = LIGHT_RED;
          t1_d     = sampled.green;
          t2_d     = sampled.red;
        end
`ifdef CONFIG_BLINK_EN
        else if (tick) begin
          l1_d = (l1_q == LIGHT_YELLOW) ? LIGHT_OFF : LIGHT_YELLOW;
          l2_d = (l2_q == LIGHT_YELLOW) ? LIGHT_OFF : LIGHT_YELLOW;
        end
`endif
      end
      default: begin
        // A mode edge pre-empts any tick in the same cycle.
        if (mode_edge) begin
          state_d = ST_CONFIG;
          cfg_d   = 1'b1;
          l1_d    = CFG_LIGHT;
          l2_d    = CFG_LIGHT;
          t1_d    = 7'd0;
          t2_d    = 7'd0;
        end else if (tick) begin
          t1_d = dec1(t1_q);
          t2_d = dec1(t2_q);
          case (state_q)
            ST_G1R2: if (t1_q == 7'd1) begin
              state_d = ST_Y1R2;
              l1_d    = LIGHT_YELLOW;
              t1_d    = shadow_q.yellow;
            end
            ST_Y1R2: if (t1_q == 7'd1) begin
              state_d = ST_R1G2;
              l1_d    = LIGHT_RED;
              l2_d    = LIGHT_GREEN;
              t1_d    = shadow_q.red;
              t2_d    = shadow_q.green;
            end
            ST_R1G2: if (t2_q == 7'd1) begin
              state_d = ST_R1Y2;
              l2_d    = LIGHT_YELLOW;
              t2_d    = shadow_q.yellow;
            end
            ST_R1Y2: if (t2_q == 7'd1) begin
              state_d  = ST_G1R2;
              shadow_d = sampled;
              l1_d     = LIGHT_GREEN;
              l2_d     = LIGHT_RED;
              t1_d     = sampled.green;
              t2_d     = sampled.red;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_G1R2;
      shadow_q   <= DEF_TIMES;
      btn_prev_q <= 1'b0;
      cfg_q      <= 1'b0;
      l1_q       <= LIGHT_GREEN;
      l2_q       <= LIGHT_RED;
      t1_q       <= 7'(DEF_GREEN);
      t2_q       <= 7'(DEF_RED);
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      btn_prev_q <= bus.buttonMode;
      cfg_q      <= cfg_d;
      l1_q       <= l1_d;
      l2_q       <= l2_d;
      t1_q       <= t1_d;
      t2_q       <= t2_d;
    end
  end

  assign bus.configEnable = cfg_q;
  assign bus.lightLane1   = l1_q;
  assign bus.lightLane2   = l2_q;
  assign bus.timeLane1    = t1_q;
  assign bus.timeLane2    = t2_q;

endmodule
